prog_clk_div: RTL

- Runtime-programmable, multi-channel clock/tick divider driven from the 50 MHz board clock.
- Each channel produces a 50%-duty divided clock and a one-cycle enable tick.
- Divisors are loaded over a simple strobe interface, so game/UI logic can retune rates (beat tempo, scan, blink) without resynthesis.
- A global SYNC phase-aligns all channels.

---
 rtl/prog_clk_div.sv | 116 +++++++++++
 1 files changed

// File: rtl/prog_clk_div.sv
// prog_clk_div
//   Runtime-programmable, multi-channel clock/tick divider running from the
//   50 MHz board clock. Each channel divides by (N+1) to produce a one-cycle
//   TICK and a 50%-duty CLK_OUT at half the tick rate. New divisors are
//   written through a LOAD strobe, and a global SYNC restarts all channels in
//   phase.
//
// Ports
//   CLK_50M   in   1       system clock, rising edge
//   RST_N     in   1       synchronous active-low reset
//   EN        in   NUM_CH  per-channel run enable
//   SYNC      in   1       strobe: restart every channel at count 0
//   LOAD      in   1       strobe: write LOAD_DIV to channel LOAD_CH
//   LOAD_CH   in   4       target channel (indices >= NUM_CH are ignored)
//   LOAD_DIV  in   CNT_W   new divisor N
//   CLK_OUT   out  NUM_CH  divided clock, f/(2(N+1))
//   TICK      out  NUM_CH  one-cycle pulse, f/(N+1)
//   PEND      out  NUM_CH  a loaded divisor is waiting for the next wrap

module prog_clk_div #(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 28,
  parameter int unsigned DEF_DIV = 24999
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              LOAD,
  input  logic [3:0]        LOAD_CH,
  input  logic [CNT_W-1:0]  LOAD_DIV,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] PEND
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

  // Per-channel count, divisor currently in use, and divisor waiting to be
  // applied at the next wrap.
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  act [NUM_CH];
  logic [CNT_W-1:0]  shd [NUM_CH];

  logic [NUM_CH-1:0] load_hit;
  logic [NUM_CH-1:0] wrap;

  // Channel decode for LOAD and end-of-period detection. An out-of-range
  // LOAD_CH simply never matches any channel, so it leaves all state alone.
  always_comb begin
    load_hit = '0;
    wrap     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_hit[i] = LOAD && (LOAD_CH == 4'(i));
      wrap[i]     = (cnt[i] == act[i]);
    end
  end

  // Channel state. Priority is reset, then SYNC, then the per-channel
  // load/count behaviour. A divisor only replaces the active one at a period
  // boundary (wrap or SYNC), or immediately when the channel is stopped, so
  // the counter can never run past a smaller new divisor.
  always_ff @(posedge CLK_50M) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!RST_N) begin
        cnt[i]     <= '0;
        act[i]     <= DEF_N;
        shd[i]     <= DEF_N;
        CLK_OUT[i] <= 1'b0;
        TICK[i]    <= 1'b0;
        PEND[i]    <= 1'b0;
      end else if (SYNC) begin
        cnt[i]     <= '0;
        CLK_OUT[i] <= 1'b0;
        TICK[i]    <= 1'b0;
        PEND[i]    <= 1'b0;
        if (load_hit[i]) begin
          act[i] <= LOAD_DIV;
          shd[i] <= LOAD_DIV;
        end else if (PEND[i]) begin
          act[i] <= shd[i];
        end
      end else if (!EN[i]) begin
        // Stopped: hold count and clock. A load takes effect at once and
        // restarts the period from zero.
        TICK[i] <= 1'b0;
        if (load_hit[i]) begin
          act[i]  <= LOAD_DIV;
          shd[i]  <= LOAD_DIV;
          cnt[i]  <= '0;
          PEND[i] <= 1'b0;
        end
      end else if (wrap[i]) begin
        // Period boundary: a load on this very edge bypasses the shadow.
        cnt[i]     <= '0;
        CLK_OUT[i] <= ~CLK_OUT[i];
        TICK[i]    <= 1'b1;
        PEND[i]    <= 1'b0;
        if (load_hit[i]) begin
          act[i] <= LOAD_DIV;
          shd[i] <= LOAD_DIV;
        end else if (PEND[i]) begin
          act[i] <= shd[i];
        end
      end else begin
        cnt[i]  <= cnt[i] + CNT_W'(1);
        TICK[i] <= 1'b0;
        if (load_hit[i]) begin
          shd[i]  <= LOAD_DIV;
          PEND[i] <= 1'b1;
        end
      end
    end
  end

endmodule
